uart_fifo: RTL

//  Parametrised UART for the SoC peripheral bus: programmable bit period,

---
 rtl/uart_fifo_if.sv | 13 +
 rtl/uart_fifo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_if.sv
// Bus slot shared with the simple UART: read strobe, write strobe with data,
// read data and write-wait back to the master.
`timescale 1ns/1ps
interface uart_fifo_if;
    logic        re;
    logic        we;
    logic [31:0] so;
    logic [31:0] si;
    logic        wa;

    modport master (output re, output we, output so, input si, input wa);
    modport slave  (input re, input we, input so, output si, output wa);
endinterface

// File: rtl/uart_fifo.sv
// Buffered UART: programmable bit period, data width and stop bits, TX/RX
// FIFOs, mid-bit RX sampling behind a two-flop synchroniser, sticky
// framing-error and overrun flags.
`timescale 1ns/1ps
module uart_fifo #(
    parameter int DIV       = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rst,
    uart_fifo_if.slave bus,
    output logic       tx,
    input  logic       rx,
    output logic       ferr,
    output logic       ovr
);
    localparam int CW  = $clog2(DIV);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    localparam logic [CW-1:0]  BIT_END   = CW'(DIV - 1);
    localparam logic [CW-1:0]  MID_END   = CW'(DIV / 2 - 1);
    localparam logic [BW-1:0]  LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic           LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [TAW:0]   TX_ONE    = 1;
    localparam logic [RAW:0]   RX_ONE    = 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------------------------------------------------------- TX FIFO
    logic [DATA_BITS-1:0] r_tx_mem [TX_DEPTH];
    logic [TAW:0]         r_tx_wp, r_tx_rp;
    logic                 w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
    logic [DATA_BITS-1:0] w_tx_head;
    logic                 w_unused_so;

    assign w_tx_empty  = (r_tx_wp == r_tx_rp);
    assign w_tx_full   = (r_tx_wp[TAW] != r_tx_rp[TAW]) &&
                         (r_tx_wp[TAW-1:0] == r_tx_rp[TAW-1:0]);
    assign bus.wa      = bus.we && w_tx_full;
    assign w_tx_push   = bus.we && !w_tx_full;
    assign w_tx_head   = r_tx_mem[r_tx_rp[TAW-1:0]];
    assign w_unused_so = ^bus.so[31:DATA_BITS];

    // TX storage write port (no reset needed on the array)
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[TAW-1:0]] <= bus.so[DATA_BITS-1:0];
    end

    // TX pointer update on push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + TX_ONE;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_ONE;
        end
    end

    // ---------------------------------------------------------------- TX FSM
    state_t               r_tx_state;
    logic [CW-1:0]        r_tx_cnt;
    logic [BW-1:0]        r_tx_bit;
    logic                 r_tx_stop;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx;
    logic                 w_tx_tick;

    assign w_tx_tick = (r_tx_cnt == BIT_END);
    // A frame is fetched from IDLE, or straight from the end of the last stop
    // bit so consecutive frames have no idle gap.
    assign w_tx_pop  = !w_tx_empty &&
                       ((r_tx_state == S_IDLE) ||
                        (r_tx_state == S_STOP && w_tx_tick && r_tx_stop == LAST_STOP));

    // TX frame sequencer with registered serial output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_stop  <= 1'b0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_shift <= w_tx_head;
                        r_tx       <= 1'b0;
                        r_tx_cnt   <= '0;
                        r_tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tx_tick) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_state <= S_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == LAST_BIT) begin
                            r_tx       <= 1'b1;
                            r_tx_stop  <= 1'b0;
                            r_tx_state <= S_STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + BW'(1);
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx       <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        if (r_tx_stop == LAST_STOP) begin
                            if (w_tx_pop) begin
                                r_tx_shift <= w_tx_head;
                                r_tx       <= 1'b0;
                                r_tx_state <= S_START;
                            end else begin
                                r_tx_state <= S_IDLE;
                            end
                        end else begin
                            r_tx_stop <= 1'b1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end

    assign tx = r_tx;

    // ---------------------------------------------------------------- RX path
    logic r_rx_s1, r_rx_s2;
    logic w_rx;

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    assign w_rx = r_rx_s2;

    state_t               r_rx_state;
    logic [CW-1:0]        r_rx_cnt;
    logic [BW-1:0]        r_rx_bit;
    logic                 r_rx_stop;
    logic                 r_rx_stop_ok;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 w_rx_tick, w_rx_done, w_rx_frame_ok;

    assign w_rx_tick     = (r_rx_cnt == BIT_END);
    assign w_rx_done     = (r_rx_state == S_STOP) && w_rx_tick && (r_rx_stop == LAST_STOP);
    assign w_rx_frame_ok = r_rx_stop_ok && w_rx;

    // RX frame sequencer sampling each bit at its centre
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state   <= S_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_stop    <= 1'b0;
            r_rx_stop_ok <= 1'b1;
            r_rx_shift   <= '0;
        end else begin
            case (r_rx_state)
                S_IDLE: begin
                    if (!w_rx) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_rx_cnt == MID_END) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= w_rx ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == LAST_BIT) begin
                            r_rx_stop    <= 1'b0;
                            r_rx_stop_ok <= 1'b1;
                            r_rx_state   <= S_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + BW'(1);
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_rx_tick) begin
                        r_rx_cnt <= '0;
                        if (r_rx_stop == LAST_STOP) begin
                            r_rx_state <= S_IDLE;
                        end else begin
                            r_rx_stop    <= 1'b1;
                            r_rx_stop_ok <= r_rx_stop_ok & w_rx;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- RX FIFO
    logic [DATA_BITS-1:0] r_rx_mem [RX_DEPTH];
    logic [RAW:0]         r_rx_wp, r_rx_rp;
    logic                 w_rx_empty, w_rx_full, w_rx_pop, w_rx_push;
    logic                 w_ferr_set, w_ovr_set;
    logic                 r_ferr, r_ovr;

    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[RAW] != r_rx_rp[RAW]) &&
                        (r_rx_wp[RAW-1:0] == r_rx_rp[RAW-1:0]);
    assign w_rx_pop   = bus.re && !w_rx_empty;
    // A pop in the same cycle frees the slot the new frame lands in.
    assign w_rx_push  = w_rx_done && w_rx_frame_ok && (!w_rx_full || w_rx_pop);
    assign w_ferr_set = w_rx_done && !w_rx_frame_ok;
    assign w_ovr_set  = w_rx_done && w_rx_frame_ok && w_rx_full && !w_rx_pop;

    assign bus.si = w_rx_empty ? '1
                               : {{(32-DATA_BITS){1'b0}}, r_rx_mem[r_rx_rp[RAW-1:0]]};

    // RX storage write port
    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp[RAW-1:0]] <= r_rx_shift;
    end

    // RX pointer update on push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + RX_ONE;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_ONE;
        end
    end

    // Sticky error flags: set wins over the clear-on-read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_ferr_set)  r_ferr <= 1'b1;
            else if (bus.re) r_ferr <= 1'b0;
            if (w_ovr_set)   r_ovr  <= 1'b1;
            else if (bus.re) r_ovr  <= 1'b0;
        end
    end

    assign ferr = r_ferr;
    assign ovr  = r_ovr;
endmodule
